// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes and read-master FSM states
package axi_lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;
  typedef enum logic [1:0] {IDLE, AR, R, DONE} rd_state_t;
endpackage

// File: rtl/axi_rd_fifo2.sv
// axi_rd_fifo2: two-entry FIFO; a push into a full FIFO is taken only alongside a pop
module axi_rd_fifo2 #(
  parameter int W = 35
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic wp, rp, do_push, do_pop;
  logic [1:0] cnt;
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign dout = mem[rp];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/axi_lite_read_master.sv
// axi_lite_read_master: issues single-beat AXI4-Lite reads per command and streams the words out
module axi_lite_read_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 12,
  parameter int ADDR_STEP   = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic [DATA_W-1:0] dout_data_o,
  output logic [1:0]        dout_resp_o,
  output logic              dout_last_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  rd_state_t state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] remaining;
  logic [WD_W-1:0] wd_cnt;
  logic [DATA_W+2:0] head;
  logic fifo_full, fifo_empty, cmd_fire, ar_fire, r_fire, wd_tick, last_beat;
  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_fire = M_AXI_RVALID && M_AXI_RREADY;
  assign last_beat = remaining == LEN_W'(1);
  // A beat held off only by our own full FIFO is not the slave's fault
  assign wd_tick = state == R && !r_fire && !(M_AXI_RVALID && fifo_full);
  assign M_AXI_ARADDR = addr;
  assign M_AXI_ARPROT = 3'b000;
  assign dout_valid_o = !fifo_empty;
  assign {dout_data_o, dout_resp_o, dout_last_o} = head;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = cmd_valid_i ? (cmd_len_i != '0 ? AR : DONE) : IDLE;
      AR:      state_nxt = M_AXI_ARREADY ? R : AR;
      R:       state_nxt = r_fire ? (last_beat ? DONE : AR) : R;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready_o = state == IDLE && ARESETN;
    M_AXI_ARVALID = state == AR;
    M_AXI_RREADY = state == R && !fifo_full;
    done_o = state == DONE;
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr <= '0;
      remaining <= '0;
      wd_cnt <= '0;
      err_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr <= cmd_addr_i;
        remaining <= cmd_len_i;
        err_o <= 1'b0;
        timeout_o <= 1'b0;
      end
      if (ar_fire) begin
        addr <= addr + ADDR_W'(ADDR_STEP);
        wd_cnt <= '0;
      end
      if (r_fire) remaining <= remaining - LEN_W'(1);
      if (r_fire && resp_t'(M_AXI_RRESP) != OKAY) err_o <= 1'b1;
      if (wd_tick && wd_cnt != WD_W'(TIMEOUT_CYC)) wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_tick && wd_cnt == WD_W'(TIMEOUT_CYC - 1)) timeout_o <= 1'b1;
    end
  end
  axi_rd_fifo2 #(.W(DATA_W + 3)) u_fifo (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .push   (r_fire),
    .din    ({M_AXI_RDATA, M_AXI_RRESP, last_beat}),
    .pop    (dout_ready_i),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
endmodule

// File: tb/tb_axi_lite_read_master.sv
// tb_axi_lite_read_master: directed commands against a simple AXI-Lite slave with a scoreboard on dout
module tb_axi_lite_read_master;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic cmd_valid_i = 1'b0;
  logic cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic [11:0] cmd_len_i = '0;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0] M_AXI_ARPROT;
  logic M_AXI_ARVALID;
  logic M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0] M_AXI_RRESP = '0;
  logic M_AXI_RVALID = 1'b0;
  logic M_AXI_RREADY;
  logic [31:0] dout_data_o;
  logic [1:0] dout_resp_o;
  logic dout_last_o, dout_valid_o, done_o, err_o, timeout_o;
  logic dout_ready_i = 1'b1;
  int checks = 0, failures = 0;
  int ar_wait = 0, ar_cycles = 0, done_cnt = 0, ar_stall = 0;
  bit r_hold = 0, r_drop = 0, ar_pend = 0;
  logic [31:0] err_addr = '1;
  logic [34:0] sb[$];
  logic [31:0] aq[$];

  axi_lite_read_master #(.TIMEOUT_CYC(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .dout_data_o(dout_data_o), .dout_resp_o(dout_resp_o), .dout_last_o(dout_last_o),
    .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
    .done_o(done_o), .err_o(err_o), .timeout_o(timeout_o)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic exp_word(input logic [31:0] d, input logic [1:0] r, input logic l);
    sb.push_back({d, r, l});
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [11:0] l);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_addr_i = a;
    cmd_len_i = l;
    while (!cmd_ready_o && n < 50) begin
      tick;
      n++;
    end
    chk(cmd_ready_o, "cmd_ready", 64'(cmd_ready_o), 64'd1);
    tick;
    cmd_valid_i = 1'b0;
    chk(M_AXI_ARVALID == (l != 0), "arvalid_latency", 64'(M_AXI_ARVALID), 64'(l != 0));
    chk({err_o, timeout_o} == 2'b00, "flags_clear_on_accept", 64'({err_o, timeout_o}), 64'd0);
  endtask

  task automatic finish_cmd(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      tick;
      n++;
    end
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick;
      n++;
    end
    repeat (3) tick;
    chk(done_cnt == d0 + 1, "done_pulses", 64'(done_cnt - d0), 64'd1);
    chk(sb.size() == 0, "words_delivered", 64'(sb.size()), 64'd0);
  endtask

  // AXI-Lite slave: data is 0xBEEF in the top half and the word address in the bottom half
  initial begin
    logic [31:0] a;
    forever begin
      tick;
      if (ARESETN && M_AXI_ARVALID) begin
        repeat (ar_stall) tick;
        M_AXI_ARREADY = 1'b1;
        a = M_AXI_ARADDR;
        tick;
        M_AXI_ARREADY = 1'b0;
        while (r_hold) tick;
        if (r_drop) begin
          M_AXI_RVALID = 1'b1;
          repeat (3) begin
            chk(!M_AXI_RREADY, "stale_rready", 64'(M_AXI_RREADY), 64'd0);
            tick;
          end
          M_AXI_RVALID = 1'b0;
        end else begin
          int n = 0;
          M_AXI_RVALID = 1'b1;
          M_AXI_RDATA = {16'hBEEF, a[15:0]};
          M_AXI_RRESP = (a == err_addr) ? 2'b10 : 2'b00;
          while (!M_AXI_RREADY && n < 300) begin
            tick;
            n++;
          end
          if (n == 300) chk(1'b0, "rready_timeout", 64'd0, 64'd1);
          tick;
          M_AXI_RVALID = 1'b0;
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (!ARESETN) ar_pend <= 1'b0;
    else begin
      if (done_o) done_cnt++;
      if (ar_pend && !M_AXI_ARVALID) chk(1'b0, "arvalid_dropped", 64'd0, 64'd1);
      ar_pend <= M_AXI_ARVALID && !M_AXI_ARREADY;
      if (M_AXI_ARVALID) begin
        ar_cycles++;
        if (!M_AXI_ARREADY) ar_wait++;
        if (aq.size() == 0) chk(1'b0, "ar_unexpected", 64'(M_AXI_ARADDR), 64'd0);
        else begin
          chk({M_AXI_ARPROT, M_AXI_ARADDR} == {3'b000, aq[0]}, "araddr", 64'({M_AXI_ARPROT, M_AXI_ARADDR}), 64'({3'b000, aq[0]}));
          if (M_AXI_ARREADY) aq.delete(0);
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (ARESETN && dout_valid_o && dout_ready_i) begin
      if (sb.size() == 0) chk(1'b0, "dout_extra_word", 64'({dout_data_o, dout_resp_o, dout_last_o}), 64'd0);
      else begin
        logic [34:0] e;
        e = sb.pop_front();
        chk({dout_data_o, dout_resp_o, dout_last_o} == e, "dout_word", 64'({dout_data_o, dout_resp_o, dout_last_o}), 64'(e));
      end
    end
  end

  initial begin
    int d, w, a, n;
    repeat (2) @(negedge ACLK);
    chk({M_AXI_ARVALID, M_AXI_RREADY, dout_valid_o, done_o, err_o, timeout_o, cmd_ready_o} == 7'b0, "reset_outputs",
        64'({M_AXI_ARVALID, M_AXI_RREADY, dout_valid_o, done_o, err_o, timeout_o, cmd_ready_o}), 64'd0);
    chk(M_AXI_ARADDR == 32'h0, "reset_araddr", 64'(M_AXI_ARADDR), 64'd0);
    tick;
    ARESETN = 1'b1;
    tick;
    chk(cmd_ready_o, "ready_after_reset", 64'(cmd_ready_o), 64'd1);
    // 1: three back-to-back words
    d = done_cnt;
    aq.push_back(32'h10); aq.push_back(32'h11); aq.push_back(32'h12);
    exp_word(32'hBEEF0010, 2'd0, 1'b0);
    exp_word(32'hBEEF0011, 2'd0, 1'b0);
    exp_word(32'hBEEF0012, 2'd0, 1'b1);
    send_cmd(32'h10, 12'd3);
    finish_cmd(d);
    chk(err_o == 1'b0, "t1_err", 64'(err_o), 64'd0);
    // 2: slave stalls ARREADY for 5 cycles
    ar_stall = 5;
    d = done_cnt;
    w = ar_wait;
    aq.push_back(32'h20);
    exp_word(32'hBEEF0020, 2'd0, 1'b1);
    send_cmd(32'h20, 12'd1);
    finish_cmd(d);
    chk(ar_wait - w == 5, "ar_stall_cycles", 64'(ar_wait - w), 64'd5);
    ar_stall = 0;
    // 3: downstream stalled, FIFO fills and back-pressures the slave
    dout_ready_i = 1'b0;
    d = done_cnt;
    aq.push_back(32'h30); aq.push_back(32'h31); aq.push_back(32'h32); aq.push_back(32'h33);
    exp_word(32'hBEEF0030, 2'd0, 1'b0);
    exp_word(32'hBEEF0031, 2'd0, 1'b0);
    exp_word(32'hBEEF0032, 2'd0, 1'b0);
    exp_word(32'hBEEF0033, 2'd0, 1'b1);
    send_cmd(32'h30, 12'd4);
    repeat (30) tick;
    chk({dout_valid_o, M_AXI_RVALID, M_AXI_RREADY} == 3'b110, "backpressure",
        64'({dout_valid_o, M_AXI_RVALID, M_AXI_RREADY}), 64'b110);
    chk(sb.size() == 4, "no_early_pop", 64'(sb.size()), 64'd4);
    dout_ready_i = 1'b1;
    finish_cmd(d);
    chk(timeout_o == 1'b0, "t3_no_timeout", 64'(timeout_o), 64'd0);
    // 4: second beat returns SLVERR
    err_addr = 32'h41;
    d = done_cnt;
    aq.push_back(32'h40); aq.push_back(32'h41); aq.push_back(32'h42);
    exp_word(32'hBEEF0040, 2'd0, 1'b0);
    exp_word(32'hBEEF0041, 2'd2, 1'b0);
    exp_word(32'hBEEF0042, 2'd0, 1'b1);
    send_cmd(32'h40, 12'd3);
    finish_cmd(d);
    chk(err_o == 1'b1, "err_sticky", 64'(err_o), 64'd1);
    err_addr = '1;
    // 5: slave withholds RVALID, watchdog fires after 8 cycles in R
    r_hold = 1'b1;
    d = done_cnt;
    aq.push_back(32'h50);
    exp_word(32'hBEEF0050, 2'd0, 1'b1);
    send_cmd(32'h50, 12'd1);
    n = 0;
    @(negedge ACLK);
    while (!(M_AXI_ARVALID && M_AXI_ARREADY) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk(n < 50, "t5_ar_handshake", 64'(n), 64'd0);
    repeat (8) @(negedge ACLK);
    chk(timeout_o == 1'b0, "timeout_early", 64'(timeout_o), 64'd0);
    @(negedge ACLK);
    chk(timeout_o == 1'b1, "timeout_set", 64'(timeout_o), 64'd1);
    tick;
    r_hold = 1'b0;
    finish_cmd(d);
    chk(timeout_o == 1'b1, "timeout_sticky", 64'(timeout_o), 64'd1);
    // 6: zero-length command
    a = ar_cycles;
    d = done_cnt;
    send_cmd(32'h60, 12'd0);
    repeat (3) tick;
    chk(done_cnt == d + 1, "len0_done", 64'(done_cnt - d), 64'd1);
    chk(ar_cycles == a, "len0_no_ar", 64'(ar_cycles - a), 64'd0);
    // reset while a read is outstanding
    r_hold = 1'b1;
    aq.push_back(32'h68);
    send_cmd(32'h68, 12'd2);
    n = 0;
    while (!M_AXI_RREADY && n < 50) begin
      tick;
      n++;
    end
    chk(M_AXI_RREADY, "mid_r_reached", 64'(M_AXI_RREADY), 64'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    chk({M_AXI_ARVALID, M_AXI_RREADY, dout_valid_o, done_o, err_o, timeout_o, cmd_ready_o} == 7'b0, "async_reset_outputs",
        64'({M_AXI_ARVALID, M_AXI_RREADY, dout_valid_o, done_o, err_o, timeout_o, cmd_ready_o}), 64'd0);
    chk(M_AXI_ARADDR == 32'h0, "async_reset_araddr", 64'(M_AXI_ARADDR), 64'd0);
    tick;
    tick;
    ARESETN = 1'b1;
    r_drop = 1'b1;
    r_hold = 1'b0;
    repeat (6) tick;
    r_drop = 1'b0;
    d = done_cnt;
    aq.push_back(32'h70); aq.push_back(32'h71);
    exp_word(32'hBEEF0070, 2'd0, 1'b0);
    exp_word(32'hBEEF0071, 2'd0, 1'b1);
    send_cmd(32'h70, 12'd2);
    finish_cmd(d);
    chk(aq.size() == 0, "all_ar_issued", 64'(aq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
